// File: rtl/instr_fetch_unit.sv
// Purpose : PC generation and instruction fetch for the IF stage, feeding the IF/ID register.
// Latency : a hit delivers its word in the request cycle; an N-cycle miss delivers it on cycle N+1.
// Backpressure: stall parks a returned word in hold_buf (HELD) so it is never read from memory twice.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   stall                      downstream cannot accept an instruction this cycle
//   branch_taken/target        EX-stage redirect; highest priority
//   imem_read/address          request to instruction memory, held stable while imem_busywait=1
//   imem_readdata/busywait     memory response and not-ready indication
//   pc, pc_4                   address of the presented instruction and its successor
//   instruction, instr_valid   fetched word (or NOP bubble) and its consume strobe
//   miss_cycles                saturating count of memory-wait cycles while fetching
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] miss_cycles
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HELD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] miss_cycles_q, miss_cycles_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_buf_d    = hold_buf_q;
    redirect_pc_d = redirect_pc_q;
    miss_cycles_d = miss_cycles_q;
    imem_read     = 1'b0;
    imem_address  = pc_q;
    instr_valid   = 1'b0;
    instruction   = NOP_INSTR;

    // Any wait cycle on an outstanding request counts, whether the word will be used or squashed.
    if ((state_q != ST_HELD) && imem_busywait && (miss_cycles_q != 32'hFFFF_FFFF)) begin
      miss_cycles_d = miss_cycles_q + 32'd1;
    end

    case (state_q)
      ST_RUN: begin
        imem_read = 1'b1;
        if (branch_taken && !imem_busywait) begin
          pc_d = branch_target;
        end else if (branch_taken) begin
          // The request cannot be withdrawn mid-miss; let it finish in KILL and drop the data.
          redirect_pc_d = branch_target;
          state_d       = ST_KILL;
        end else if (imem_busywait) begin
          pc_d = pc_q;
        end else if (!stall) begin
          instr_valid = 1'b1;
          instruction = imem_readdata;
          pc_d        = pc_q + 32'd4;
        end else begin
          hold_buf_d = imem_readdata;
          state_d    = ST_HELD;
        end
      end

      ST_HELD: begin
        instruction = hold_buf_q;
        instr_valid = !stall && !branch_taken;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = ST_RUN;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_RUN;
        end
      end

      ST_KILL: begin
        imem_read = 1'b1;
        if (branch_taken) begin
          redirect_pc_d = branch_target;
        end
        if (!imem_busywait) begin
          pc_d    = branch_taken ? branch_target : redirect_pc_q;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // The reset cycle issues no request and presents a bubble regardless of state.
    if (reset) begin
      imem_read   = 1'b0;
      instr_valid = 1'b0;
      instruction = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      hold_buf_q    <= 32'd0;
      redirect_pc_q <= 32'd0;
      miss_cycles_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_buf_q    <= hold_buf_d;
      redirect_pc_q <= redirect_pc_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign pc          = pc_q;
  assign pc_4        = pc_q + 32'd4;
  assign miss_cycles = miss_cycles_q;

endmodule
